cmp_operand_loader: RTL
=======================

CMP_OPERAND_LOADER -- requirements
Module: cmp_operand_loader

Interface
REQ-001 Parameter: GAP_MAX, default 15, max idle cycles allowed between accepted serial bits within a frame; range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ser_in  input  1  serial operand bit, MSB first: A[3..0], then B[3..0].
REQ-005 ser_valid  input  1  ser_in valid; a bit is accepted when ser_valid and ser_ready are both 1.
REQ-006 ser_ready  output  1  loader can accept a serial bit.
REQ-007 a  output  4  operand A presented to the downstream 4-bit comparator.
REQ-008 b  output  4  operand B presented to the downstream 4-bit comparator.
REQ-009 op_valid  output  1  a/b complete; one-cycle pulse.
REQ-010 a_gb, a_lb, a_eb  input  1 each  comparator flags (combinational from a/b).
REQ-011 res  output  3  latched {gt, lt, eq}.
REQ-012 res_valid  output  1  res valid; held until res_ready.
REQ-013 res_ready  input  1  consumer accepts res when res_valid and res_ready are both 1.
REQ-014 err  output  1  sticky frame/result error; cleared only by reset or err_clr.
REQ-015 err_clr  input  1  synchronous clear of err.

Function
REQ-016 FSM states: IDLE, SHIFT, EVAL, HOLD.
REQ-017 IDLE: ser_ready=1; an accepted bit loads the shift register, sets bit count to 1, and moves to SHIFT.
REQ-018 SHIFT: ser_ready=1; each accepted bit shifts in at the LSB and increments the count; on the 8th bit (9th with parity), move to EVAL.
REQ-019 Gap rule: in SHIFT, a gap counter resets on each accepted bit. If it reaches GAP_MAX, discard the frame, set err, and return to IDLE; the bit arriving on the timeout cycle is not accepted.
REQ-020 a and b update only on entry to EVAL, and hold their values in all other states.
REQ-021 EVAL: lasts one cycle; op_valid=1 and ser_ready=0. Sample a_gb/a_lb/a_eb into res and move to HOLD.
REQ-022 Flag check in EVAL: if the flags are not one-hot, set err and still latch res.
REQ-023 HOLD: res_valid=1, ser_ready=0. On res_ready=1, go to IDLE with res_valid=0 in the next cycle; res is held.
REQ-024 Latency: the last serial bit accepted in cycle N gives op_valid in N+1 and res_valid from N+2.
REQ-025 Throughput: with res_ready tied high, consecutive frames need no extra idle cycles beyond the EVAL and HOLD cycles.
REQ-026 err_clr and a new error condition in the same cycle: err remains 1.
REQ-027 ser_valid=0 in IDLE: no state change, gap counter inactive.

Reset
REQ-028 rst_n low, asynchronously: state=IDLE, a=0, b=0, res=0, op_valid=0, res_valid=0, err=0, counters=0, and ser_ready=1 after release.
REQ-029 Reset mid-frame or in HOLD: the partial frame and pending result are dropped with no op_valid or res_valid pulse.

Configuration
REQ-030 Macro CMP_PARITY_EN defined: the frame is 9 bits, and the 9th bit is even parity over A and B. On mismatch, set err, suppress op_valid, skip EVAL, and return to IDLE.
REQ-031 CMP_PARITY_EN undefined: the frame is 8 bits and no parity logic is present.

Verification
REQ-032 Serial 1000_1011 with gt/lt/eq=010 from the model -> op_valid pulse, a=1000, b=1011, res=010, res_valid until res_ready, err=0.
REQ-033 Serial 1110_1110, with res_ready held low 5 cycles -> res=001 held stable, ser_ready=0 throughout, IDLE one cycle after res_ready.
REQ-034 4 bits sent, then ser_valid low for GAP_MAX cycles -> err=1, no op_valid, next frame 1010_0111 gives res=100.
REQ-035 Comparator model forced to flags 011 -> err=1, res=011; err_clr then clears err to 0.
REQ-036 rst_n pulsed low after the 6th bit -> outputs zero immediately, no op_valid; fresh frame 0000_1001 gives res=010.
REQ-037 With CMP_PARITY_EN: 1000_1011 with parity bit 1 -> err=1, no op_valid; with parity bit 0 -> normal result.

Source files
------------

// File: rtl/cmp_operand_loader.sv
// Serial operand loader for a 4-bit comparator: shifts A/B in MSB-first, presents them,
// latches the comparator flags and holds the result. Optional macro CMP_PARITY_EN adds a 9th even-parity bit.
module cmp_operand_loader #(
  parameter int unsigned GAP_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_in,
  input  logic       ser_valid,
  output logic       ser_ready,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       op_valid,
  input  logic       a_gb,
  input  logic       a_lb,
  input  logic       a_eb,
  output logic [2:0] res,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       err,
  input  logic       err_clr
);

`ifdef CMP_PARITY_EN
  localparam int FRAME_W = 9;
`else
  localparam int FRAME_W = 8;
`endif
  localparam int CNT_W = 4;
  localparam int GAP_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_EVAL,
    S_HOLD
  } state_t;

  state_t             r_state, w_state_next;
  logic [FRAME_W-2:0] r_sr, w_sr_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [GAP_W-1:0]   r_gap, w_gap_next;
  logic [3:0]         r_a, w_a_next;
  logic [3:0]         r_b, w_b_next;
  logic [2:0]         r_res, w_res_next;
  logic               r_err, w_err_next;

  logic               w_err_set;
  logic               w_ser_ready;
  logic               w_op_valid;
  logic               w_res_valid;
  logic [FRAME_W-1:0] w_frame;
  logic [7:0]         w_ab;
  logic [2:0]         w_flags;
  logic               w_last_bit;
  logic               w_timeout;
  logic               w_flags_onehot;
  logic               w_frame_ok;

  // w_frame is the complete frame as it would look once the current bit is shifted in.
  assign w_frame        = {r_sr, ser_in};
  assign w_ab           = w_frame[FRAME_W-1 -: 8];
  assign w_last_bit     = (r_cnt == CNT_W'(FRAME_W - 1));
  assign w_timeout      = (r_gap >= GAP_W'(GAP_MAX));
  assign w_flags        = {a_gb, a_lb, a_eb};
  assign w_flags_onehot = (w_flags == 3'b100) || (w_flags == 3'b010) || (w_flags == 3'b001);

`ifdef CMP_PARITY_EN
  // Even parity: the nine received bits must contain an even number of ones.
  assign w_frame_ok = ~(^w_frame);
`else
  assign w_frame_ok = 1'b1;
`endif

  always_comb begin
    w_state_next = r_state;
    w_sr_next    = r_sr;
    w_cnt_next   = r_cnt;
    w_gap_next   = r_gap;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_res_next   = r_res;
    w_err_next   = r_err;
    w_err_set    = 1'b0;
    w_ser_ready  = 1'b0;
    w_op_valid   = 1'b0;
    w_res_valid  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_ser_ready = 1'b1;
        if (ser_valid) begin
          w_sr_next    = {{(FRAME_W-2){1'b0}}, ser_in};
          w_cnt_next   = CNT_W'(1);
          w_gap_next   = '0;
          w_state_next = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (w_timeout) begin
          // Ready is withheld on the timeout cycle so a late bit cannot slip into a dropped frame.
          w_err_set    = 1'b1;
          w_sr_next    = '0;
          w_cnt_next   = '0;
          w_gap_next   = '0;
          w_state_next = S_IDLE;
        end else begin
          w_ser_ready = 1'b1;
          if (ser_valid) begin
            w_sr_next  = w_frame[FRAME_W-2:0];
            w_gap_next = '0;
            if (w_last_bit) begin
              w_cnt_next = '0;
              if (w_frame_ok) begin
                w_a_next     = w_ab[7:4];
                w_b_next     = w_ab[3:0];
                w_state_next = S_EVAL;
              end else begin
                w_err_set    = 1'b1;
                w_state_next = S_IDLE;
              end
            end else begin
              w_cnt_next = r_cnt + CNT_W'(1);
            end
          end else begin
            w_gap_next = r_gap + GAP_W'(1);
          end
        end
      end

      S_EVAL: begin
        w_op_valid   = 1'b1;
        w_res_next   = w_flags;
        w_err_set    = ~w_flags_onehot;
        w_state_next = S_HOLD;
      end

      S_HOLD: begin
        w_res_valid = 1'b1;
        if (res_ready) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // A new error in the same cycle as a clear request wins.
    if (err_clr) begin
      w_err_next = 1'b0;
    end
    if (w_err_set) begin
      w_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sr    <= w_sr_next;
      r_cnt   <= w_cnt_next;
      r_gap   <= w_gap_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_res   <= w_res_next;
      r_err   <= w_err_next;
    end
  end

  assign ser_ready = w_ser_ready;
  assign op_valid  = w_op_valid;
  assign res_valid = w_res_valid;
  assign a         = r_a;
  assign b         = r_b;
  assign res       = r_res;
  assign err       = r_err;

endmodule
